instr_fetch: RTL

- Fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues reads to a synchronous instruction ROM with 1-cycle read latency.
- Buffers returned 16-bit words in a 2-entry FIFO and presents them to the decoder over a valid/ready handshake.
- Supports start/stop control and auto-halts on a designated halt word.

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 103 ++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM read port plus the valid/ready
// handshake toward the decoder.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [15:0]       imem_rdata;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_addr, imem_rd, instr, instr_valid,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_addr, imem_rd, instr, instr_valid,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, 1-cycle-latency ROM reads, 2-entry return
// FIFO toward the decoder, start/stop control and halt-word detection.
module instr_fetch #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  instr_fetch_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic        outstanding;
  logic [15:0] fifo_mem [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;

  logic        fifo_wr;
  logic        fifo_rd;
  logic        halt_hit;
  logic        issue;
  logic [1:0]  credit_used;

  always_comb begin
    fifo_wr     = outstanding;
    fifo_rd     = (count != 2'd0) && bus.instr_ready;
    halt_hit    = fifo_wr && (bus.imem_rdata == HALT_WORD);
    // A pop in this cycle frees its slot for a read issued now; without this
    // the stage cannot sustain one instruction per cycle.
    credit_used = count + 2'(outstanding) - 2'(fifo_rd);
    issue       = (state == RUN) && !stop && !halt_hit && (credit_used < 2'd2);
  end

  assign bus.imem_rd     = issue;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = fifo_mem[rptr];
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      outstanding <= 1'b0;
    end else begin
      outstanding <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          if (issue) pc <= pc + ADDR_W'(1);
          if (stop || halt_hit) state <= DRAIN;
        end
        DRAIN: begin
          if (!outstanding && (count == 2'd0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wptr] <= bus.imem_rdata;
        wptr           <= ~wptr;
      end
      if (fifo_rd) rptr <= ~rptr;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(fifo_wr && (count == 2'd2) && !fifo_rd)
  );

endmodule
